// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 block controller and compression core.
package sha256_pkg;

  localparam int unsigned SHA256_ROUNDS = 64;
  localparam int unsigned WORD_W        = 32;
  localparam int unsigned HALF_W        = 256;
  localparam int unsigned BLOCK_W       = 512;

  typedef enum logic [2:0] {
    WAIT_LO,
    WAIT_HI,
    LOAD,
    ROUND,
    UPDATE,
    OUT
  } state_e;

  localparam logic [HALF_W-1:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // Round constants, indexed by round number
  localparam logic [WORD_W-1:0] SHA256_K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

endpackage

// File: rtl/sha256_round_counter.sv
// Round index counter: clear has priority, wraps to zero after the terminal count.
module sha256_round_counter
  import sha256_pkg::*;
#(
  parameter int unsigned rounds_p = SHA256_ROUNDS,
  localparam int unsigned CntW = (rounds_p > 1) ? $clog2(rounds_p) : 1
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            clear_i,
  input  logic            en_i,
  output logic [CntW-1:0] count_o,
  output logic            tc_o
);

  logic [CntW-1:0] count_q, count_d;

  assign tc_o    = (count_q == CntW'(rounds_p - 1));
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = tc_o ? '0 : count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sha256_block_ctrl.sv
// Pairs upstream half-blocks into 512-bit blocks and sequences the SHA-256 core
// through load, rounds and hash update, chaining blocks until the last one.
module sha256_block_ctrl
  import sha256_pkg::*;
#(
  parameter int unsigned rounds_p      = SHA256_ROUNDS,
  parameter int unsigned count_width_p = 16,
  localparam int unsigned RoundW = (rounds_p > 1) ? $clog2(rounds_p) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     chunk_v_i,
  input  logic [HALF_W-1:0]        chunk_data_i,
  input  logic                     chunk_last_i,
  output logic                     chunk_yumi_o,
  output logic [BLOCK_W-1:0]       core_block_o,
  output logic                     core_init_o,
  output logic                     core_load_o,
  output logic                     core_round_en_o,
  output logic [RoundW-1:0]        core_round_o,
  output logic                     core_update_o,
  input  logic [HALF_W-1:0]        core_digest_i,
  output logic                     digest_v_o,
  output logic [HALF_W-1:0]        digest_o,
  input  logic                     digest_yumi_i,
  output logic                     busy_o,
  output logic [count_width_p-1:0] block_count_o
);

  state_e                   state_q, state_d;
  logic                     first_q, first_d;
  logic                     last_q;
  logic [BLOCK_W-1:0]       block_q;
  logic [count_width_p-1:0] count_q;
  logic                     lo_en, hi_en, cnt_clr, cnt_en, cnt_tc;
  logic [RoundW-1:0]        round_cnt;

  sha256_round_counter #(.rounds_p(rounds_p)) u_round_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (cnt_clr),
    .en_i    (cnt_en),
    .count_o (round_cnt),
    .tc_o    (cnt_tc)
  );

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= WAIT_LO;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
    end
  end

  // Half-block capture; contents stay put from LOAD through UPDATE
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      block_q <= '0;
      last_q  <= 1'b0;
    end else begin
      if (lo_en) block_q[BLOCK_W-1:HALF_W] <= chunk_data_i;
      if (hi_en) begin
        block_q[HALF_W-1:0] <= chunk_data_i;
        last_q              <= chunk_last_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      count_q <= '0;
    end else if (core_update_o) begin
      count_q <= count_q + count_width_p'(1);
    end
  end

  assign core_block_o  = block_q;
  assign block_count_o = count_q;

  always_comb begin
    state_d         = state_q;
    first_d         = first_q;
    lo_en           = 1'b0;
    hi_en           = 1'b0;
    cnt_clr         = 1'b0;
    cnt_en          = 1'b0;
    chunk_yumi_o    = 1'b0;
    core_init_o     = 1'b0;
    core_load_o     = 1'b0;
    core_round_en_o = 1'b0;
    core_round_o    = '0;
    core_update_o   = 1'b0;
    digest_v_o      = 1'b0;
    digest_o        = '0;
    busy_o          = (state_q != WAIT_LO);
    case (state_q)
      WAIT_LO: begin
        chunk_yumi_o = chunk_v_i;
        lo_en        = chunk_v_i;
        if (chunk_v_i) state_d = WAIT_HI;
      end
      WAIT_HI: begin
        chunk_yumi_o = chunk_v_i;
        hi_en        = chunk_v_i;
        if (chunk_v_i) state_d = LOAD;
      end
      LOAD: begin
        core_load_o = 1'b1;
        core_init_o = first_q;
        cnt_clr     = 1'b1;
        state_d     = ROUND;
      end
      ROUND: begin
        core_round_en_o = 1'b1;
        core_round_o    = round_cnt;
        cnt_en          = 1'b1;
        if (cnt_tc) state_d = UPDATE;
      end
      UPDATE: begin
        core_update_o = 1'b1;
        if (last_q) begin
          state_d = OUT;
        end else begin
          first_d = 1'b0;
          state_d = WAIT_LO;
        end
      end
      OUT: begin
        digest_v_o = 1'b1;
        digest_o   = core_digest_i;
        if (digest_yumi_i) begin
          first_d = 1'b1;
          state_d = WAIT_LO;
        end
      end
      default: state_d = WAIT_LO;
    endcase
  end

endmodule
